// File: rtl/cpu_arb_pkg.sv
// Shared types and the rotate-priority pick helper for the CPU issue arbiter.
package cpu_arb_pkg;

  localparam int ARB_MAX_NR = 8;
  localparam int ARB_IDX_W  = 3;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  typedef struct packed {
    logic                 found;
    logic [ARB_IDX_W-1:0] idx;
  } rr_pick_t;

  // First valid index scanning ptr, ptr+1, ... and wrapping at nr.
  function automatic rr_pick_t rr_pick(
    input logic [ARB_MAX_NR-1:0] valid,
    input logic [ARB_IDX_W-1:0]  ptr,
    input logic [ARB_IDX_W:0]    nr
  );
    rr_pick_t             res;
    logic [ARB_IDX_W:0]   off_w;
    logic [ARB_IDX_W:0]   sum;
    logic [ARB_IDX_W:0]   k;
    logic                 hit;
    res.found = 1'b0;
    res.idx   = 3'd0;
    for (int off = 0; off < ARB_MAX_NR; off++) begin
      off_w     = 4'(off);
      sum       = {1'b0, ptr} + off_w;
      k         = (sum >= nr) ? (sum - nr) : sum;
      hit       = (off_w < nr) && valid[k[ARB_IDX_W-1:0]] && !res.found;
      res.idx   = hit ? k[ARB_IDX_W-1:0] : res.idx;
      res.found = res.found | hit;
    end
    return res;
  endfunction

endpackage

// File: rtl/cpu_rr_picker.sv
// Combinational rotate-priority encoder: picks the first valid requester at or after i_ptr.
module cpu_rr_picker
  import cpu_arb_pkg::*;
#(
  parameter int NR = 2,
  parameter int IW = 1
) (
  input  logic [NR-1:0] i_valid,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  localparam logic [ARB_IDX_W:0] NR_W = NR[ARB_IDX_W:0];

  logic [ARB_MAX_NR-1:0] w_valid;
  logic [ARB_IDX_W-1:0]  w_ptr;
  rr_pick_t              w_pick;

  // Widen to the package's fixed width and run the shared pick function.
  always_comb begin
    w_valid           = 8'd0;
    w_valid[NR-1:0]   = i_valid;
    w_ptr             = 3'd0;
    w_ptr[IW-1:0]     = i_ptr;
    w_pick            = rr_pick(w_valid, w_ptr, NR_W);
    o_found           = w_pick.found;
    o_idx             = w_pick.idx[IW-1:0];
  end

endmodule

// File: rtl/cpu_issue_arbiter.sv
// Round-robin arbiter feeding one registered tag/data slot with busy back-pressure.
// Optional requester-0 priority with starvation guard: define CPU_ISSUE_ARBITER_PRIO_EN.
module cpu_issue_arbiter
  import cpu_arb_pkg::*;
#(
  parameter int NR         = 2,
  parameter int DW         = 32,
  parameter int TW         = 8,
  parameter int MAX_STARVE = 4,
  localparam int IW        = (NR > 1) ? $clog2(NR) : 1
) (
  input  logic           i_clock,
  input  logic           i_reset,
  input  logic [NR-1:0]    i_req_valid,
  input  logic [NR*TW-1:0] i_req_tag,
  input  logic [NR*DW-1:0] i_req_data,
  output logic [NR-1:0]    o_req_busy,
  output logic           o_valid,
  output logic [TW-1:0]  o_tag,
  output logic [DW-1:0]  o_data,
  output logic [IW-1:0]  o_grant_id,
  input  logic           i_busy
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NR - 1);

  slot_state_t   r_state;
  logic [TW-1:0] r_tag;
  logic [DW-1:0] r_data;
  logic [IW-1:0] r_grant_id;
  logic [IW-1:0] r_ptr;

  logic [NR-1:0] w_pick_valid;
  logic          w_pick_found;
  logic [IW-1:0] w_pick_idx;
  logic          w_found;
  logic [IW-1:0] w_winner;
  logic          w_can_accept;
  logic          w_accept;
  logic          w_ptr_upd;
  logic [IW-1:0] w_next_ptr;
  logic [TW-1:0] w_sel_tag;
  logic [DW-1:0] w_sel_data;

  cpu_rr_picker #(
    .NR (NR),
    .IW (IW)
  ) u_picker (
    .i_valid (w_pick_valid),
    .i_ptr   (r_ptr),
    .o_found (w_pick_found),
    .o_idx   (w_pick_idx)
  );

`ifdef CPU_ISSUE_ARBITER_PRIO_EN
  localparam int SW = $clog2(MAX_STARVE + 1);

  logic [SW-1:0] r_starve;
  logic          w_force;
  logic          w_others;

  // Requester 0 wins outright unless it has starved the others for MAX_STARVE grants.
  always_comb begin
    w_force      = (r_starve >= SW'(MAX_STARVE));
    w_others     = |(i_req_valid >> 1);
    w_pick_valid = w_force ? (i_req_valid & ~NR'(1)) : i_req_valid;
    if (!w_force && i_req_valid[0]) begin
      w_found  = 1'b1;
      w_winner = '0;
    end else if (w_pick_found) begin
      w_found  = 1'b1;
      w_winner = w_pick_idx;
    end else if (i_req_valid[0]) begin
      w_found  = 1'b1;
      w_winner = '0;
    end else begin
      w_found  = 1'b0;
      w_winner = '0;
    end
  end

  // Starve counter: counts requester-0 grants taken while others wait.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_starve <= '0;
    end else if (w_accept) begin
      if (w_winner != '0) begin
        r_starve <= '0;
      end else if (!w_others) begin
        r_starve <= '0;
      end else if (r_starve < SW'(MAX_STARVE)) begin
        r_starve <= r_starve + SW'(1);
      end else begin
        r_starve <= r_starve;
      end
    end else begin
      r_starve <= r_starve;
    end
  end

  assign w_ptr_upd = w_accept && (w_winner != '0);
`else
  // Pure round-robin over every requester.
  always_comb begin
    w_pick_valid = i_req_valid;
    w_found      = w_pick_found;
    w_winner     = w_pick_idx;
  end

  assign w_ptr_upd = w_accept;
`endif

  assign w_can_accept = (r_state == SLOT_EMPTY) || !i_busy;
  assign w_accept     = w_can_accept && w_found;
  assign w_next_ptr   = (w_winner == LAST_IDX) ? '0 : (w_winner + IW'(1));

  // Winner's tag/data mux.
  always_comb begin
    w_sel_tag  = '0;
    w_sel_data = '0;
    for (int k = 0; k < NR; k++) begin
      w_sel_tag  = w_sel_tag  | ({TW{w_winner == IW'(k)}} & i_req_tag[k*TW +: TW]);
      w_sel_data = w_sel_data | ({DW{w_winner == IW'(k)}} & i_req_data[k*DW +: DW]);
    end
  end

  // Only the accepted requester sees busy low; everyone is held off in reset.
  always_comb begin
    if (!i_reset) begin
      o_req_busy = '1;
    end else if (w_accept) begin
      o_req_busy = ~(NR'(1) << w_winner);
    end else begin
      o_req_busy = '1;
    end
  end

  // Output slot: load on accept (also covers drain+refill), empty on drain, hold on stall.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= SLOT_EMPTY;
      r_tag      <= '0;
      r_data     <= '0;
      r_grant_id <= '0;
    end else if (w_accept) begin
      r_state    <= SLOT_FULL;
      r_tag      <= w_sel_tag;
      r_data     <= w_sel_data;
      r_grant_id <= w_winner;
    end else if ((r_state == SLOT_FULL) && !i_busy) begin
      r_state    <= SLOT_EMPTY;
      r_tag      <= r_tag;
      r_data     <= r_data;
      r_grant_id <= r_grant_id;
    end else begin
      r_state    <= r_state;
      r_tag      <= r_tag;
      r_data     <= r_data;
      r_grant_id <= r_grant_id;
    end
  end

  // Round-robin pointer moves past the winner.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_ptr <= '0;
    end else if (w_ptr_upd) begin
      r_ptr <= w_next_ptr;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign o_valid    = (r_state == SLOT_FULL);
  assign o_tag      = r_tag;
  assign o_data     = r_data;
  assign o_grant_id = r_grant_id;

endmodule

// File: tb/tb_cpu_issue_arbiter.sv
// Directed bench for cpu_issue_arbiter (NR=3) with a per-cycle reference model.
module tb_cpu_issue_arbiter;

  localparam int NR = 3;
  localparam int DW = 32;
  localparam int TW = 8;
  localparam int MS = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]    req_valid;
  logic [NR*TW-1:0] req_tag;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_busy;
  logic            o_valid;
  logic [TW-1:0]   o_tag;
  logic [DW-1:0]   o_data;
  logic [IW-1:0]   o_grant_id;
  logic            busy_dn;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_issue_arbiter #(.NR(NR), .DW(DW), .TW(TW), .MAX_STARVE(MS)) dut (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .i_req_valid(req_valid),
    .i_req_tag  (req_tag),
    .i_req_data (req_data),
    .o_req_busy (req_busy),
    .o_valid    (o_valid),
    .o_tag      (o_tag),
    .o_data     (o_data),
    .o_grant_id (o_grant_id),
    .i_busy     (busy_dn)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: slot contents, pointer and starve count as plain integers.
  logic          m_valid;
  logic [TW-1:0] m_tag;
  logic [DW-1:0] m_data;
  int            m_gid;
  int            m_ptr;
  int            m_starve;
  int            e_win;
  logic          e_acc;
  logic [NR-1:0] e_busy;

  function automatic int model_winner(input logic [NR-1:0] v, input int ptr, input int starve);
    int k;
`ifdef CPU_ISSUE_ARBITER_PRIO_EN
    if (starve < MS && v[0]) return 0;
`endif
    for (int off = 0; off < NR; off++) begin
      k = (ptr + off) % NR;
`ifdef CPU_ISSUE_ARBITER_PRIO_EN
      if (v[k] && !(starve >= MS && k == 0)) return k;
`else
      if (v[k]) return k;
`endif
    end
`ifdef CPU_ISSUE_ARBITER_PRIO_EN
    if (v[0]) return 0;
`endif
    return -1;
  endfunction

  always_comb begin
    e_win  = model_winner(req_valid, m_ptr, m_starve);
    e_acc  = rst_n && (!m_valid || !busy_dn) && (e_win >= 0);
    e_busy = '1;
    if (e_acc) e_busy[e_win] = 1'b0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_tag <= '0; m_data <= '0;
      m_gid <= 0; m_ptr <= 0; m_starve <= 0;
    end else if (e_acc) begin
      m_valid <= 1'b1;
      m_tag   <= req_tag[e_win*TW +: TW];
      m_data  <= req_data[e_win*DW +: DW];
      m_gid   <= e_win;
`ifdef CPU_ISSUE_ARBITER_PRIO_EN
      if (e_win != 0) begin
        m_ptr <= (e_win + 1) % NR;
        m_starve <= 0;
      end else if (req_valid[NR-1:1] != '0) begin
        m_starve <= (m_starve < MS) ? m_starve + 1 : m_starve;
      end else begin
        m_starve <= 0;
      end
`else
      m_ptr <= (e_win + 1) % NR;
`endif
    end else if (m_valid && !busy_dn) begin
      m_valid <= 1'b0;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("model_req_busy", 64'(req_busy), 64'(e_busy));
    chk("model_valid", 64'(o_valid), 64'(m_valid));
    if (m_valid) begin
      chk("model_tag", 64'(o_tag), 64'(m_tag));
      chk("model_data", 64'(o_data), 64'(m_data));
      chk("model_grant", 64'(o_grant_id), 64'(m_gid));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_rr [4] = '{32'h100, 32'h101, 32'h102, 32'h100};
`ifdef CPU_ISSUE_ARBITER_PRIO_EN
  int exp_pat [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`else
  int exp_pat [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`endif

  initial begin
    busy_dn   = 1'b0;
    req_valid = 3'b111;
    for (int k = 0; k < NR; k++) begin
      req_tag[k*TW +: TW]  = 8'h10 + 8'(k);
      req_data[k*DW +: DW] = 32'h100 + 32'(k);
    end
    #1;
    chk("reset_valid", 64'(o_valid), 64'd0);
    chk("reset_tag", 64'(o_tag), 64'd0);
    chk("reset_data", 64'(o_data), 64'd0);
    chk("reset_grant", 64'(o_grant_id), 64'd0);
    chk("reset_req_busy", 64'(req_busy), 64'b111);
    tick(); tick();
    rst_n = 1'b1;

    // All requesting: grants 0,1,2,0 back to back.
    #1 chk("rr_first_busy", 64'(req_busy), 64'b110);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_data", 64'(o_data), 64'(exp_rr[i]));
      chk("rr_valid", 64'(o_valid), 64'd1);
    end

    // Stall with requester 1 in the slot.
    req_tag[1*TW +: TW] = 8'h33;
    req_valid = 3'b010;
    tick();
    chk("stall_load_tag", 64'(o_tag), 64'h33);
    chk("stall_load_grant", 64'(o_grant_id), 64'd1);
    busy_dn = 1'b1;
    req_valid = 3'b111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_tag", 64'(o_tag), 64'h33);
      chk("stall_data", 64'(o_data), 64'h101);
      chk("stall_grant", 64'(o_grant_id), 64'd1);
      chk("stall_req_busy", 64'(req_busy), 64'b111);
    end
    busy_dn = 1'b0;
    #1 chk("release_req_busy", 64'(req_busy), 64'b011);
    tick();
    chk("release_grant", 64'(o_grant_id), 64'd2);

    // Only requester 2, pointer at 0.
    req_data[2*DW +: DW] = 32'h202;
    req_valid = 3'b100;
    tick();
    chk("only2_grant", 64'(o_grant_id), 64'd2);
    chk("only2_data", 64'(o_data), 64'h202);
    req_valid = 3'b111;
    #1 chk("wrap_ptr_busy", 64'(req_busy), 64'b110);
    tick();
    chk("wrap_grant", 64'(o_grant_id), 64'd0);

    // Requester 1 requests for one stalled cycle, then withdraws.
    busy_dn = 1'b1;
    req_valid = 3'b010;
    tick();
    chk("withdraw_hold_grant", 64'(o_grant_id), 64'd0);
    req_valid = 3'b000;
    tick();
    busy_dn = 1'b0;
    #1 chk("withdraw_req_busy", 64'(req_busy), 64'b111);
    tick();
    chk("withdraw_drained", 64'(o_valid), 64'd0);
    chk("withdraw_never_1", 64'(o_grant_id), 64'd0);

    // Reset while FULL and stalled.
    req_tag[0*TW +: TW] = 8'h5A;
    req_valid = 3'b001;
    tick();
    chk("pre_reset_tag", 64'(o_tag), 64'h5A);
    busy_dn = 1'b1;
    req_valid = 3'b111;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 64'(o_valid), 64'd0);
    chk("async_reset_tag", 64'(o_tag), 64'd0);
    chk("async_reset_busy", 64'(req_busy), 64'b111);
    tick(); tick();
    rst_n = 1'b1;
    busy_dn = 1'b0;
    #1 chk("post_reset_busy", 64'(req_busy), 64'b110);

    // First grant after reset goes to 0, then requesters 0 and 1 compete.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("pattern_grant", 64'(o_grant_id), 64'(exp_pat[i]));
      req_valid = 3'b011;
    end

    req_valid = 3'b000;
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_issue_arbiter.md
Name: cpu_issue_arbiter

Overview:
- Round-robin arbiter that shares one tagged pipeline stage (tag + data, busy back-pressure) between NR upstream requesters.
- Winning request is captured into a registered output slot, so the stage boundary gets one cycle of latency and full throughput.
- Sits in front of a shared CPU pipeline resource, e.g. the writeback or memory port fed by fetch and load/store paths, and drives that stage's busy-handshaked input.

Parameters:
- NR, 2, number of requesters (1..8).
- DW, 32, data width.
- TW, 8, tag width.
- MAX_STARVE, 4, consecutive priority grants allowed before a forced round-robin grant (used only with the optional feature).

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_req_valid  in  NR  per-requester request.
- i_req_tag  in  NR*TW  packed tags, requester k at [k*TW +: TW].
- i_req_data  in  NR*DW  packed data, requester k at [k*DW +: DW].
- o_req_busy  out  NR  1 = request not accepted this cycle; requester holds tag/data.
- o_valid  out  1  output slot holds a transfer.
- o_tag  out  TW  output tag.
- o_data  out  DW  output data.
- o_grant_id  out  $clog2(NR) (min 1)  index of the requester owning the slot.
- i_busy  in  1  downstream stall.

Behaviour:
- Reset (i_reset low, asynchronous):
  - o_valid=0, o_tag=0, o_data=0, o_grant_id=0.
  - RR pointer=0; starve counter=0.
  - o_req_busy is all-ones while reset is asserted.
- Slot states:
  - EMPTY (o_valid=0) and FULL (o_valid=1).
  - can_accept = EMPTY, or FULL with i_busy=0.
- Winner selection (combinational):
  - First k with i_req_valid[k]=1, scanning ptr, ptr+1, …, NR-1, 0, …, ptr-1.
- Accept (can_accept=1 and a winner exists):
  - Next edge: slot loads winner's tag/data, o_grant_id=winner, o_valid=1.
  - ptr = winner+1, wrapping NR-1 -> 0.
  - o_req_busy[winner]=0 in the accept cycle; all others 1.
- Drain (FULL, i_busy=0, no winner): o_valid=0 next edge (FULL -> EMPTY).
- Stall (FULL, i_busy=1):
  - o_valid, o_tag, o_data and o_grant_id hold bit-stable.
  - o_req_busy is all-ones; ptr is unchanged.
- Simultaneous drain and accept in the same cycle is allowed: slot stays FULL with the new contents, giving back-to-back throughput of 1/cycle.
- Request lines may drop without acceptance; the arbiter is not sticky and re-arbitrates every cycle.
- Fairness: with all NR requesting and i_busy=0, grants rotate 0,1,…,NR-1; each requester waits at most NR-1 accepts.
- NR=1: behaves as a registered one-entry skid stage; o_grant_id=0.
- Upstream sees o_req_busy in the same cycle as i_busy (combinational path); no combinational path from i_req_* to o_valid/o_tag/o_data.

Optional Feature:
- CPU_ISSUE_ARBITER_PRIO_EN defined:
  - Requester 0 has strict priority over the round-robin order.
  - A starve counter increments on each grant to 0 while any other requester is pending, and clears on any other grant.
  - When the counter reaches MAX_STARVE, the next accept ignores requester 0 and uses the round-robin order over 1..NR-1.
  - ptr updates only on non-0 grants.
- Not defined: pure round-robin over all requesters; no starve counter logic is synthesized.

Decomposition:
- cpu_arb_pkg holds:
  - constant ARB_MAX_NR=8
  - typedef enum {SLOT_EMPTY, SLOT_FULL} slot_state_t
  - function rr_pick(valid, ptr) returning the index and a found flag
- Natural sub-module: cpu_rr_picker, a combinational rotate-priority encoder, parameterised by NR.
- The top level owns the slot register, pointer and starve counter.

Test Plan:
- Reset mid-transfer: FULL with tag 0x5A and i_busy=1, drop i_reset -> o_valid=0 at once; after release, first grant goes to requester 0 when all request.
- NR=3, all requesting, i_busy=0, data k=0x100+k -> o_data sequence 0x100,0x101,0x102,0x100; o_valid continuous; one accept per cycle.
- Stall: FULL with requester 1 tag 0x33, i_busy=1 for 5 cycles -> o_tag/o_data/o_grant_id stable; o_req_busy=3'b111; release -> requester 2 accepted the same cycle.
- Only requester 2 requesting, ptr=0 -> granted; ptr wraps to 0; o_grant_id=2.
- Request withdrawn: requester 1 asserts for one stalled cycle then drops -> never granted; slot drains to EMPTY after i_busy falls.
- PRIO_EN, MAX_STARVE=4, requesters 0 and 1 continuously requesting -> grant pattern 0,0,0,0,1,0,0,0,0,1.
